// File: rtl/vector_frame_accumulator_if.sv
// ---------------------------------------------------------------------------
// vector_frame_accumulator_if
//
// Purpose:
//   Vector stream bundle carried between the filter/reduce stage, the frame
//   accumulator and the data-packing stage. One beat is one N-lane vector
//   tagged with its chain and its frame-boundary flags.
//
// Signals:
//   valid     beat qualifier
//   bof       first vector of a frame (qualified by valid)
//   eof       last vector of a frame (qualified by valid)
//   chain_id  instrumentation chain that owns the vector
//   vector    N lanes of DATA_WIDTH unsigned bits
//
// Modports:
//   master    drives the stream
//   slave     receives the stream
// ---------------------------------------------------------------------------
interface vector_frame_accumulator_if #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int CHAIN_W    = 2
);
    logic                             valid;
    logic                             bof;
    logic                             eof;
    logic [CHAIN_W-1:0]               chain_id;
    logic [N-1:0][DATA_WIDTH-1:0]     vector;

    modport master (output valid, output bof, output eof, output chain_id, output vector);
    modport slave  (input  valid, input  bof, input  eof, input  chain_id, input  vector);
endinterface

// File: rtl/vector_frame_accumulator.sv
// ---------------------------------------------------------------------------
// vector_frame_accumulator
//
// Purpose:
//   Per-chain stage after the filter/reduce stage. For each chain it either
//   passes vectors straight through (op 0) or folds every vector of a frame
//   into one summary vector by element-wise sum (op 1) or element-wise
//   unsigned max (op 2). Ops other than 1/2 behave as pass. The summary is
//   emitted on the frame's last vector with bof_out = eof_out = 1.
//   Two-stage pipeline: stage 1 registers the input beat and looks up the
//   chain's op, stage 2 does the read-modify-write of the chain accumulator
//   and registers the outputs. One vector per cycle, no backpressure.
//
// Ports:
//   clk         clock
//   reset       asynchronous active-high reset
//   tracing     1 = run, 0 = configuration mode (output silenced, in-flight
//               data dropped, firmware ops writable)
//   configId    configuration target id; this block answers PERSONAL_CONFIG_ID
//   configData  configuration byte (one op byte per chain, chain 0 first)
//   in_bus      incoming vector stream (slave)
//   out_bus     outgoing vector stream (master), valid is a 1-cycle pulse
//
// Build options:
//   ACC_SATURATE_EN  when defined, sum clamps each lane at 2^DATA_WIDTH-1
//                    instead of wrapping. Pass and max are unaffected.
// ---------------------------------------------------------------------------
module vector_frame_accumulator #(
    parameter int                      N                   = 8,
    parameter int                      DATA_WIDTH          = 32,
    parameter int                      MAX_CHAINS          = 4,
    parameter logic [7:0]              PERSONAL_CONFIG_ID  = 8'd0,
    parameter logic [MAX_CHAINS*8-1:0] INITIAL_FIRMWARE_OP = '0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                tracing,
    input  logic [7:0]                          configId,
    input  logic [7:0]                          configData,
    vector_frame_accumulator_if.slave           in_bus,
    vector_frame_accumulator_if.master          out_bus
);

    localparam int CW   = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;
    localparam int BC_W = $clog2(MAX_CHAINS + 1);

    typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;

    typedef enum logic [1:0] {
        OP_PASS = 2'd0,
        OP_SUM  = 2'd1,
        OP_MAX  = 2'd2
    } op_e;

    function automatic op_e decode_op(input logic [7:0] op_byte);
        case (op_byte)
            8'd1:    return OP_SUM;
            8'd2:    return OP_MAX;
            default: return OP_PASS;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] lane_combine(
        input op_e                   op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
`ifdef ACC_SATURATE_EN
        logic [DATA_WIDTH:0] sum_ext;
        sum_ext = {1'b0, a} + {1'b0, b};
        if (op == OP_MAX) begin
            return (a > b) ? a : b;
        end
        // A carry out of the lane means the true sum is unrepresentable.
        return sum_ext[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : sum_ext[DATA_WIDTH-1:0];
`else
        if (op == OP_MAX) begin
            return (a > b) ? a : b;
        end
        return a + b;
`endif
    endfunction

    // Firmware state and per-chain accumulator bank
    logic [7:0]            firmware_op [MAX_CHAINS];
    vec_t                  acc         [MAX_CHAINS];
    logic [MAX_CHAINS-1:0] in_frame;
    logic [BC_W-1:0]       byte_counter;

    // Stage 1 registers
    logic                  s1_valid;
    logic                  s1_bof;
    logic                  s1_eof;
    logic [CW-1:0]         s1_chain;
    vec_t                  s1_vec;
    op_e                   s1_op;

    logic                  stage2_fire;
    logic                  is_personal;
    logic [CW-1:0]         cfg_idx;
    vec_t                  base;

    assign stage2_fire = tracing && s1_valid;
    assign is_personal = (configId == PERSONAL_CONFIG_ID);
    assign cfg_idx     = CW'(byte_counter);

    // Stage 1: capture the beat and resolve the chain's op here, so any later
    // op change can never affect a vector that is already in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_bof   <= 1'b0;
            s1_eof   <= 1'b0;
            s1_chain <= '0;
            s1_vec   <= '0;
            s1_op    <= OP_PASS;
        end else begin
            s1_valid <= tracing && in_bus.valid;
            s1_bof   <= in_bus.bof;
            s1_eof   <= in_bus.eof;
            s1_chain <= in_bus.chain_id;
            s1_vec   <= in_bus.vector;
            s1_op    <= decode_op(firmware_op[in_bus.chain_id]);
        end
    end

    // A frame restarts from the incoming vector on bof or when the chain has
    // no open partial; that also covers bof+eof one-vector frames and a bof
    // that abandons an unfinished frame.
    always_comb begin
        base = s1_vec;
        if (!s1_bof && in_frame[s1_chain]) begin
            for (int i = 0; i < N; i++) begin
                base[i] = lane_combine(s1_op, acc[s1_chain][i], s1_vec[i]);
            end
        end
    end

    // Accumulator bank and firmware configuration. Stage 2 only runs while
    // tracing, so it never collides with a configuration write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < MAX_CHAINS; c++) begin
                acc[c]         <= '0;
                firmware_op[c] <= INITIAL_FIRMWARE_OP[c*8 +: 8];
            end
            in_frame     <= '0;
            byte_counter <= '0;
        end else begin
            if (stage2_fire && (s1_op != OP_PASS)) begin
                if (s1_eof) begin
                    acc[s1_chain]      <= '0;
                    in_frame[s1_chain] <= 1'b0;
                end else begin
                    acc[s1_chain]      <= base;
                    in_frame[s1_chain] <= 1'b1;
                end
            end

            // The counter stops at MAX_CHAINS so surplus bytes cannot wrap
            // around and overwrite chain 0.
            if (!is_personal) begin
                byte_counter <= '0;
            end else if (!tracing && (byte_counter < BC_W'(MAX_CHAINS))) begin
                firmware_op[cfg_idx] <= configData;
                acc[cfg_idx]         <= '0;
                in_frame[cfg_idx]    <= 1'b0;
                byte_counter         <= byte_counter + 1'b1;
            end
        end
    end

    // Stage 2 output register: pass beats go out as received, accumulated
    // frames go out once on their eof beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_bus.valid    <= 1'b0;
            out_bus.bof      <= 1'b0;
            out_bus.eof      <= 1'b0;
            out_bus.chain_id <= '0;
            out_bus.vector   <= '0;
        end else begin
            out_bus.valid <= 1'b0;
            if (stage2_fire) begin
                if (s1_op == OP_PASS) begin
                    out_bus.valid    <= 1'b1;
                    out_bus.bof      <= s1_bof;
                    out_bus.eof      <= s1_eof;
                    out_bus.chain_id <= s1_chain;
                    out_bus.vector   <= s1_vec;
                end else if (s1_eof) begin
                    out_bus.valid    <= 1'b1;
                    out_bus.bof      <= 1'b1;
                    out_bus.eof      <= 1'b1;
                    out_bus.chain_id <= s1_chain;
                    out_bus.vector   <= base;
                end
            end
        end
    end

endmodule

// File: tb/tb_vector_frame_accumulator.sv
// ---------------------------------------------------------------------------
// tb_vector_frame_accumulator
//
// Purpose:
//   Self-checking bench for vector_frame_accumulator. Directed vectors are
//   driven with hand-computed expected summaries pushed into a queue; a
//   monitor pops and compares on every valid_out pulse. Chain 3 starts in
//   sum mode through INITIAL_FIRMWARE_OP, the other chains start in pass.
//   Expected overflow result follows ACC_SATURATE_EN.
// ---------------------------------------------------------------------------
module tb_vector_frame_accumulator;

    localparam int         N          = 8;
    localparam int         DW         = 32;
    localparam int         CHAINS     = 4;
    localparam logic [7:0] MY_ID      = 8'h21;
    localparam logic [7:0] IDLE_ID    = 8'h00;

    typedef logic [N-1:0][DW-1:0] vec_t;

    typedef struct {
        int         tag;
        logic [1:0] chain;
        logic       bof;
        logic       eof;
        vec_t       vec;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       tracing;
    logic [7:0] configId;
    logic [7:0] configData;
    logic       in_config;

    int   checks;
    int   failures;
    int   tag_count;
    exp_t exp_q [$];

    vector_frame_accumulator_if #(.N(N), .DATA_WIDTH(DW), .CHAIN_W(2)) in_if ();
    vector_frame_accumulator_if #(.N(N), .DATA_WIDTH(DW), .CHAIN_W(2)) out_if ();

    vector_frame_accumulator #(
        .N                   (N),
        .DATA_WIDTH          (DW),
        .MAX_CHAINS          (CHAINS),
        .PERSONAL_CONFIG_ID  (MY_ID),
        .INITIAL_FIRMWARE_OP (32'h01_00_00_00)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tracing    (tracing),
        .configId   (configId),
        .configData (configData),
        .in_bus     (in_if),
        .out_bus    (out_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t fill(input logic [DW-1:0] value);
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = value;
        return v;
    endfunction

    function automatic vec_t ramp(input logic [DW-1:0] base, input logic [DW-1:0] step);
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = base + step * DW'(i);
        return v;
    endfunction

    task automatic pushExpected(input logic [1:0] chain, input logic bof, input logic eof, input vec_t v);
        exp_t e;
        tag_count++;
        e.tag   = tag_count;
        e.chain = chain;
        e.bof   = bof;
        e.eof   = eof;
        e.vec   = v;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic [1:0] chain, input logic bof, input logic eof, input vec_t v);
        in_if.valid    = 1'b1;
        in_if.chain_id = chain;
        in_if.bof      = bof;
        in_if.eof      = eof;
        in_if.vector   = v;
        @(posedge clk);
        #1;
        in_if.valid = 1'b0;
        in_if.bof   = 1'b0;
        in_if.eof   = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string name);
        checks++;
        if (out_if.valid !== 1'b0 || out_if.bof !== 1'b0 || out_if.eof !== 1'b0 ||
            out_if.chain_id !== 2'd0 || out_if.vector !== '0) begin
            failures++;
            $display("[TB] FAIL %s: valid=%b bof=%b eof=%b chain=%0d vector=%h, required all zero",
                     name, out_if.valid, out_if.bof, out_if.eof, out_if.chain_id, out_if.vector);
        end
    endtask

    // Opens configuration mode with a valid beat on the input that must be dropped
    task automatic enterConfig();
        tracing        = 1'b0;
        in_config      = 1'b1;
        in_if.valid    = 1'b1;
        in_if.chain_id = 2'd2;
        in_if.bof      = 1'b1;
        in_if.eof      = 1'b1;
        in_if.vector   = fill(32'd99);
    endtask

    task automatic configByte(input logic [7:0] b);
        configId   = MY_ID;
        configData = b;
        @(posedge clk);
        #1;
        in_if.valid = 1'b0;
        in_if.bof   = 1'b0;
        in_if.eof   = 1'b0;
    endtask

    task automatic leaveConfig();
        configId = IDLE_ID;
        @(posedge clk);
        #1;
        tracing = 1'b1;
        @(posedge clk);
        #1;
        in_config = 1'b0;
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (out_if.chain_id !== e.chain || out_if.bof !== e.bof || out_if.eof !== e.eof ||
            out_if.vector !== e.vec) begin
            failures++;
            $display("[TB] FAIL out#%0d: got chain=%0d bof=%b eof=%b vec=%h, required chain=%0d bof=%b eof=%b vec=%h",
                     e.tag, out_if.chain_id, out_if.bof, out_if.eof, out_if.vector,
                     e.chain, e.bof, e.eof, e.vec);
        end
    endtask

    // Monitor: samples on the falling edge, pops one expectation per pulse
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (in_config) begin
                checks++;
                if (out_if.valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL config_silent: valid_out=%b, required 0", out_if.valid);
                end
            end
            if (out_if.valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_output: got chain=%0d vec=%h, required no output",
                             out_if.chain_id, out_if.vector);
                end else begin
                    checkOutput(exp_q.pop_front());
                end
            end else if (out_if.valid !== 1'b0) begin
                checks++;
                failures++;
                $display("[TB] FAIL valid_known: valid_out=%b, required 0 or 1", out_if.valid);
            end
        end
    end

    initial begin
        logic [DW-1:0] ovf_result;
`ifdef ACC_SATURATE_EN
        ovf_result = 32'hFFFF_FFFF;
`else
        ovf_result = 32'h0000_0001;
`endif
        checks     = 0;
        failures   = 0;
        tag_count  = 0;
        in_config  = 1'b0;
        reset      = 1'b1;
        tracing    = 1'b1;
        configId   = IDLE_ID;
        configData = 8'd0;
        in_if.valid    = 1'b0;
        in_if.bof      = 1'b0;
        in_if.eof      = 1'b0;
        in_if.chain_id = 2'd0;
        in_if.vector   = '0;

        $display("[TB] reset state");
        repeat (3) begin
            @(negedge clk);
            checkIdle("reset_idle");
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] pass-through");
        pushExpected(2'd1, 1'b1, 1'b1, fill(32'd5));
        applyStimulus(2'd1, 1'b1, 1'b1, fill(32'd5));
        pushExpected(2'd0, 1'b1, 1'b0, ramp(32'd1, 32'd1));
        applyStimulus(2'd0, 1'b1, 1'b0, ramp(32'd1, 32'd1));
        idleCycles(4);

        $display("[TB] reset mid-frame on chain 3 (initial sum)");
        applyStimulus(2'd3, 1'b1, 1'b0, fill(32'd10));
        idleCycles(3);
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checkIdle("midframe_reset_idle");
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        pushExpected(2'd3, 1'b1, 1'b1, fill(32'd3));
        applyStimulus(2'd3, 1'b0, 1'b1, fill(32'd3));
        idleCycles(4);

        $display("[TB] configure chain0 sum, chain1 pass, chain2 max, chain3 sum");
        enterConfig();
        configByte(8'd1);
        configByte(8'd0);
        configByte(8'd2);
        configByte(8'd1);
        leaveConfig();

        $display("[TB] sum frame");
        applyStimulus(2'd0, 1'b1, 1'b0, fill(32'd1));
        applyStimulus(2'd0, 1'b0, 1'b0, fill(32'd2));
        pushExpected(2'd0, 1'b1, 1'b1, fill(32'd6));
        applyStimulus(2'd0, 1'b0, 1'b1, fill(32'd3));

        $display("[TB] interleaved chains");
        applyStimulus(2'd0, 1'b1, 1'b0, fill(32'd10));
        applyStimulus(2'd2, 1'b1, 1'b0, fill(32'd4));
        applyStimulus(2'd0, 1'b0, 1'b0, fill(32'd20));
        applyStimulus(2'd2, 1'b0, 1'b0, fill(32'd9));
        pushExpected(2'd0, 1'b1, 1'b1, fill(32'd60));
        applyStimulus(2'd0, 1'b0, 1'b1, fill(32'd30));
        pushExpected(2'd2, 1'b1, 1'b1, fill(32'd9));
        applyStimulus(2'd2, 1'b0, 1'b1, fill(32'd7));

        $display("[TB] overflow, per-lane sum and max, bof restart");
        applyStimulus(2'd0, 1'b1, 1'b0, fill(32'hFFFF_FFFF));
        pushExpected(2'd0, 1'b1, 1'b1, fill(ovf_result));
        applyStimulus(2'd0, 1'b0, 1'b1, fill(32'd2));
        applyStimulus(2'd3, 1'b1, 1'b0, ramp(32'd0, 32'd1));
        pushExpected(2'd3, 1'b1, 1'b1, ramp(32'd0, 32'd101));
        applyStimulus(2'd3, 1'b0, 1'b1, ramp(32'd0, 32'd100));
        applyStimulus(2'd2, 1'b1, 1'b0, ramp(32'd0, 32'd1));
        pushExpected(2'd2, 1'b1, 1'b1, {32'd7, 32'd6, 32'd5, 32'd4, 32'd4, 32'd5, 32'd6, 32'd7});
        applyStimulus(2'd2, 1'b0, 1'b1, ramp(32'd7, 32'hFFFF_FFFF));
        applyStimulus(2'd0, 1'b1, 1'b0, fill(32'd7));
        applyStimulus(2'd0, 1'b1, 1'b0, fill(32'd4));
        pushExpected(2'd0, 1'b1, 1'b1, fill(32'd9));
        applyStimulus(2'd0, 1'b0, 1'b1, fill(32'd5));

        $display("[TB] open partial on chain 0, then reconfigure");
        applyStimulus(2'd0, 1'b1, 1'b0, fill(32'd100));
        idleCycles(4);
        enterConfig();
        configByte(8'd2);
        configByte(8'd1);
        configByte(8'd0);
        configByte(8'd0);
        configByte(8'd1);
        configByte(8'd1);
        leaveConfig();

        $display("[TB] behaviour after reconfiguration");
        pushExpected(2'd0, 1'b1, 1'b1, fill(32'd8));
        applyStimulus(2'd0, 1'b0, 1'b1, fill(32'd8));
        applyStimulus(2'd0, 1'b1, 1'b0, fill(32'd3));
        applyStimulus(2'd0, 1'b0, 1'b0, fill(32'd11));
        pushExpected(2'd0, 1'b1, 1'b1, fill(32'd11));
        applyStimulus(2'd0, 1'b0, 1'b1, fill(32'd6));
        applyStimulus(2'd1, 1'b1, 1'b0, fill(32'd2));
        pushExpected(2'd1, 1'b1, 1'b1, fill(32'd7));
        applyStimulus(2'd1, 1'b0, 1'b1, fill(32'd5));
        pushExpected(2'd2, 1'b1, 1'b1, fill(32'd77));
        applyStimulus(2'd2, 1'b1, 1'b1, fill(32'd77));
        pushExpected(2'd3, 1'b0, 1'b0, fill(32'd42));
        applyStimulus(2'd3, 1'b0, 1'b0, fill(32'd42));
        idleCycles(6);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL pending_outputs: %0d outputs still expected, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
